// File: rtl/pool2d_unit.sv
// rtl/pool2d_unit.sv - streaming 2x2/stride-2 max/average pooling over raster-order pixels
module pool2d_unit #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int XW    = DATA_W + 2;
    localparam bit SGN   = (SIGNED != 0);
    localparam bit H_ODD = (IMG_H % 2) == 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              mode_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W:0]   line_buf [OUT_W];

    logic              col_last;
    logic              row_last;
    logic              row_used;
    logic [IW-1:0]     idx;
    logic [DATA_W:0]   lb;
    logic [XW-1:0]     left_x;
    logic [XW-1:0]     right_x;
    logic [XW-1:0]     lb_x;
    logic [XW-1:0]     h_x;
    logic [XW-1:0]     win_sum;
    logic [DATA_W-1:0] win;

    // Operands are widened to XW with zero- or sign-extension, so a signed
    // compare on the widened values is correct for both pixel formats.
    function automatic logic gt(input logic [XW-1:0] a, input logic [XW-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

    always_comb begin
        col_last = (col == CW'(IMG_W - 1));
        row_last = (row == RW'(IMG_H - 1));
        row_used = !(H_ODD && row_last);
        idx      = IW'(col >> 1);
        lb       = line_buf[idx];
        left_x   = {{2{SGN & hold_q[DATA_W-1]}}, hold_q};
        right_x  = {{2{SGN & in_data[DATA_W-1]}}, in_data};
        lb_x     = {SGN & lb[DATA_W], lb};
        h_x      = mode_q ? (left_x + right_x) : (gt(left_x, right_x) ? left_x : right_x);
        win_sum  = lb_x + h_x;
        // Only the low DATA_W bits survive, where logical and arithmetic shifts agree.
        win      = mode_q ? DATA_W'((win_sum + XW'(2)) >> 2)
                          : DATA_W'(gt(lb_x, h_x) ? lb_x : h_x);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= 1'b0;
            hold_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (in_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (row == '0 && col == '0)
                    mode_q <= mode;
                if (!col[0])
                    hold_q <= in_data;
                // Odd columns and odd rows are never the discarded edge, so no range check.
                if (col[0] && row[0]) begin
                    out_valid <= 1'b1;
                    out_data  <= win;
                    out_last  <= (row == RW'(2 * OUT_H - 1)) && (col == CW'(2 * OUT_W - 1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_valid && col[0] && !row[0] && row_used)
            line_buf[idx] <= h_x[DATA_W:0];
    end
endmodule

// File: tb/tb_pool2d_unit.sv
// tb/tb_pool2d_unit.sv - self-checking bench for pool2d_unit (28x28 unsigned and 5x5 signed instances)
module tb_pool2d_unit;
    localparam int AW = 28, AH = 28, BW = 5, BH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       a_mode = 1'b0, a_valid = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_out_valid, a_out_last;
    logic [7:0] a_out_data;
    logic       b_mode = 1'b0, b_valid = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_out_valid, b_out_last;
    logic [7:0] b_out_data;

    pool2d_unit #(.DATA_W(8), .IMG_W(AW), .IMG_H(AH), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .in_valid(a_valid), .in_data(a_data),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last));

    pool2d_unit #(.DATA_W(8), .IMG_W(BW), .IMG_H(BH), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_valid), .in_data(b_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pool(input int p0, input int p1, input int p2, input int p3, input bit avg);
        int m;
        if (avg) return (p0 + p1 + p2 + p3 + 2) >>> 2;
        m = p0;
        if (p1 > m) m = p1;
        if (p2 > m) m = p2;
        if (p3 > m) m = p3;
        return m;
    endfunction

    // Frame-level model: pixels kept by linear index, window evaluated from the stored frame.
    int fa[AW*AH];
    int pa = 0;
    bit ma = 0, ev_a = 0, el_a = 0;
    int ed_a = 0;
    always @(posedge clk) begin : model_a
        int r, c;
        ev_a = 0;
        if (rst) begin
            pa = 0;
        end else if (a_valid) begin
            if (pa == 0) ma = a_mode;
            fa[pa] = int'(a_data);
            r = pa / AW;
            c = pa % AW;
            if (r % 2 == 1 && c % 2 == 1 && r < 2 * (AH / 2) && c < 2 * (AW / 2)) begin
                ev_a = 1;
                ed_a = pool(fa[(r-1)*AW+c-1], fa[(r-1)*AW+c], fa[r*AW+c-1], fa[r*AW+c], ma);
                el_a = (r == 2 * (AH / 2) - 1) && (c == 2 * (AW / 2) - 1);
            end
            pa = (pa == AW * AH - 1) ? 0 : pa + 1;
        end
    end

    int fb[BW*BH];
    int pb = 0;
    bit mb = 0, ev_b = 0, el_b = 0;
    int ed_b = 0;
    always @(posedge clk) begin : model_b
        int r, c;
        ev_b = 0;
        if (rst) begin
            pb = 0;
        end else if (b_valid) begin
            if (pb == 0) mb = b_mode;
            fb[pb] = int'($signed(b_data));
            r = pb / BW;
            c = pb % BW;
            if (r % 2 == 1 && c % 2 == 1 && r < 2 * (BH / 2) && c < 2 * (BW / 2)) begin
                ev_b = 1;
                ed_b = pool(fb[(r-1)*BW+c-1], fb[(r-1)*BW+c], fb[r*BW+c-1], fb[r*BW+c], mb);
                el_b = (r == 2 * (BH / 2) - 1) && (c == 2 * (BW / 2) - 1);
            end
            pb = (pb == BW * BH - 1) ? 0 : pb + 1;
        end
    end

    logic [8:0] got_a[$];
    logic [8:0] got_b[$];
    logic [8:0] snap[$];

    always @(negedge clk) begin
        check("a_out_valid", a_out_valid, ev_a);
        if (ev_a) begin
            check("a_out_data", a_out_data, ed_a & 255);
            check("a_out_last", a_out_last, el_a);
        end
        if (a_out_valid) got_a.push_back({a_out_last, a_out_data});
        check("b_out_valid", b_out_valid, ev_b);
        if (ev_b) begin
            check("b_out_data", b_out_data, ed_b & 255);
            check("b_out_last", b_out_last, el_b);
        end
        if (b_out_valid) got_b.push_back({b_out_last, b_out_data});
    end

    logic [7:0] src[AW*AH];
    int bmax[BW*BH] = '{-128, -1, 10, 20, 127,  -5, -3, 30, -40, 127,
                        1, 2, 3, 4, 127,  -9, -8, -7, -6, 127,  127, 127, 127, 127, 127};
    int bavg[BW*BH] = '{-1, -2, 5, 6, 127,  -2, -2, 7, 8, 127,
                        0, 1, 2, 3, 127,  -4, -5, -6, -7, 127,  127, 127, 127, 127, 127};

    task automatic drive_a(input bit v, input logic [7:0] d, input bit m);
        @(posedge clk);
        #1;
        rst = 1'b0; a_valid = v; a_data = d; a_mode = m; b_valid = 1'b0;
    endtask

    task automatic drive_b(input bit v, input logic [7:0] d, input bit m);
        @(posedge clk);
        #1;
        rst = 1'b0; b_valid = v; b_data = d; b_mode = m; a_valid = 1'b0;
    endtask

    task automatic run_a(input bit m, input int gap, input int toggle_at);
        for (int i = 0; i < AW * AH; i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap)
                drive_a(1'b0, 8'($urandom), m);
            drive_a(1'b1, src[i], (toggle_at >= 0 && i >= toggle_at) ? !m : m);
        end
        repeat (3) drive_a(1'b0, 8'h00, 1'b0);
    endtask

    function automatic int count_last_a();
        int n = 0;
        foreach (got_a[k]) if (got_a[k][8]) n++;
        return n;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", a_out_valid, 0);
        check("reset_out_data", a_out_data, 0);
        check("reset_out_last", a_out_last, 0);

        // Incremental data, max mode
        for (int i = 0; i < AW * AH; i++) src[i] = 8'(i % 256);
        got_a.delete();
        run_a(1'b0, 0, -1);
        check("inc_max_count", got_a.size(), 196);
        check("inc_max_out0", got_a[0][7:0], 29);
        check("inc_max_out1", got_a[1][7:0], 31);
        check("inc_max_out13", got_a[13][7:0], 55);
        check("inc_max_last_count", count_last_a(), 1);
        check("inc_max_last_195", got_a[195][8], 1);

        // Same stream, average mode
        got_a.delete();
        run_a(1'b1, 0, -1);
        check("inc_avg_count", got_a.size(), 196);
        check("inc_avg_out0", got_a[0][7:0], 15);
        check("inc_avg_out1", got_a[1][7:0], 17);

        // Random data: continuous versus gapped
        for (int i = 0; i < AW * AH; i++) src[i] = 8'($urandom);
        got_a.delete();
        run_a(1'b1, 0, -1);
        snap = got_a;
        got_a.delete();
        run_a(1'b1, 30, -1);
        check("gap_count", got_a.size(), snap.size());
        foreach (snap[k]) check("gap_vs_cont", got_a[k], snap[k]);

        // Reset at pixel 400, asserted together with a valid pixel
        for (int i = 0; i < AW * AH; i++) src[i] = 8'(i % 256);
        for (int i = 0; i < 400; i++) drive_a(1'b1, src[i], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; a_valid = 1'b1; a_data = src[400];
        got_a.delete();
        run_a(1'b0, 0, -1);
        check("after_rst_count", got_a.size(), 196);
        check("after_rst_out0", got_a[0][7:0], 29);

        // Back-to-back frames: max, then average with mode toggled mid-frame
        got_a.delete();
        for (int i = 0; i < AW * AH; i++) drive_a(1'b1, src[i], 1'b0);
        run_a(1'b1, 0, 300);
        check("b2b_count", got_a.size(), 392);
        check("b2b_f1_out0", got_a[0][7:0], 29);
        check("b2b_f2_out0", got_a[196][7:0], 15);
        check("b2b_last_count", count_last_a(), 2);
        check("b2b_last_f1", got_a[195][8], 1);
        check("b2b_last_f2", got_a[391][8], 1);

        // 5x5 signed: max frame then average frame back to back
        got_b.delete();
        for (int i = 0; i < BW * BH; i++) drive_b(1'b1, 8'(bmax[i]), 1'b0);
        for (int i = 0; i < BW * BH; i++) drive_b(1'b1, 8'(bavg[i]), 1'b1);
        repeat (3) drive_b(1'b0, 8'h00, 1'b0);
        check("odd_count", got_b.size(), 8);
        check("odd_max_out0", got_b[0][7:0], 8'hFF);
        check("odd_max_out1", got_b[1][7:0], 30);
        check("odd_max_last", got_b[3][8], 1);
        check("odd_avg_neg_out0", got_b[4][7:0], 8'hFE);
        check("odd_avg_last", got_b[7][8], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
